// File: rtl/timed_event_scheduler_pkg.sv
// Shared types and constants for the timed event scheduler.
// Optional feature macro: TIMED_EVENT_SCHEDULER_LATE_DROP_EN (see top-level file).
package timed_event_scheduler_pkg;

    localparam int TS_WIDTH           = 64;
    localparam int LATE_COUNT_WIDTH   = 16;
    localparam int DEFAULT_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        FIRE = 2'd3
    } state_e;

    typedef struct packed {
        logic [TS_WIDTH-1:0]           ts;
        logic [DEFAULT_DATA_WIDTH-1:0] data;
    } event_t;

    // Saturating increment used by the late-event counter.
    function automatic logic [LATE_COUNT_WIDTH-1:0] sat_inc(input logic [LATE_COUNT_WIDTH-1:0] v);
        return (v == {LATE_COUNT_WIDTH{1'b1}}) ? v : v + LATE_COUNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/timed_event_scheduler_event_fifo.sv
// Synchronous first-word-fall-through FIFO holding {timestamp, payload} entries.
module event_fifo #(
    parameter int WIDTH    = 128,
    parameter int DEPTH    = 16,
    parameter int ADDR_LEN = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                push,
    input  logic                pop,
    input  logic [WIDTH-1:0]    wr_data,
    output logic [WIDTH-1:0]    rd_data,
    output logic                full,
    output logic                empty,
    output logic [ADDR_LEN:0]   count
);

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [ADDR_LEN-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_LEN-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_LEN:0]   count_q, count_d;
    logic                wr_en_s, rd_en_s;

    assign full    = (count_q == (ADDR_LEN+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign wr_en_s = push & ~full & ~flush;
    assign rd_en_s = pop & ~empty & ~flush;

    // Pointer and occupancy update; flush wins over any push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en_s) wr_ptr_d = wr_ptr_q + ADDR_LEN'(1);
            else         wr_ptr_d = wr_ptr_q;
            if (rd_en_s) rd_ptr_d = rd_ptr_q + ADDR_LEN'(1);
            else         rd_ptr_d = rd_ptr_q;
            case ({wr_en_s, rd_en_s})
                2'b10:   count_d = count_q + (ADDR_LEN+1)'(1);
                2'b01:   count_d = count_q - (ADDR_LEN+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (wr_en_s) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/timed_event_scheduler.sv
// Releases buffered timestamped events in order once the timestamp counter reaches them.
// Optional: define TIMED_EVENT_SCHEDULER_LATE_DROP_EN to discard late events instead of releasing them.
module timed_event_scheduler
    import timed_event_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int FIFO_DEPTH    = 16,
    parameter int FIFO_ADDR_LEN = 4
) (
    input  logic                        s_axi_aclk,
    input  logic                        s_axi_aresetn,
    input  logic [TS_WIDTH-1:0]         counter,
    input  logic                        run,
    input  logic                        flush,
    input  logic                        in_valid,
    input  logic [TS_WIDTH-1:0]         in_timestamp,
    input  logic [DATA_WIDTH-1:0]       in_data,
    output logic                        in_ready,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [DATA_WIDTH-1:0]       evt_data,
    output logic                        evt_late,
    output logic [LATE_COUNT_WIDTH-1:0] late_count,
    output logic [FIFO_ADDR_LEN:0]      fill_level
);

    localparam int ENTRY_W = TS_WIDTH + DATA_WIDTH;

    state_e                      state_q, state_d;
    logic [TS_WIDTH-1:0]         head_ts_q, head_ts_d;
    logic [DATA_WIDTH-1:0]       head_data_q, head_data_d;
    logic                        late_q, late_d;
    logic                        evt_valid_q, evt_valid_d;
    logic [DATA_WIDTH-1:0]       evt_data_q, evt_data_d;
    logic                        evt_late_q, evt_late_d;
    logic [LATE_COUNT_WIDTH-1:0] late_count_q, late_count_d;
    logic                        ready_en_q;

    logic [ENTRY_W-1:0]          fifo_rd_data_s;
    logic                        fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
    logic [FIFO_ADDR_LEN:0]      fifo_count_s;
    logic                        late_inc_s, is_late_s;

    assign in_ready    = ready_en_q & ~fifo_full_s;
    assign fifo_push_s = in_valid & in_ready & ~flush;
    assign is_late_s   = (counter > head_ts_q);

    event_fifo #(
        .WIDTH    (ENTRY_W),
        .DEPTH    (FIFO_DEPTH),
        .ADDR_LEN (FIFO_ADDR_LEN)
    ) u_event_fifo (
        .clk     (s_axi_aclk),
        .rst_n   (s_axi_aresetn),
        .flush   (flush),
        .push    (fifo_push_s),
        .pop     (fifo_pop_s),
        .wr_data ({in_timestamp, in_data}),
        .rd_data (fifo_rd_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    // Scheduler FSM: a pop into the head register always lands in LOAD.
    always_comb begin
        state_d     = state_q;
        head_ts_d   = head_ts_q;
        head_data_d = head_data_q;
        late_d      = late_q;
        evt_valid_d = evt_valid_q;
        evt_data_d  = evt_data_q;
        evt_late_d  = evt_late_q;
        fifo_pop_s  = 1'b0;
        late_inc_s  = 1'b0;
        if (flush) begin
            state_d     = IDLE;
            evt_valid_d = 1'b0;
            late_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty_s) begin
                        fifo_pop_s               = 1'b1;
                        {head_ts_d, head_data_d} = fifo_rd_data_s;
                        state_d                  = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
                LOAD: begin
                    late_d = is_late_s;
`ifdef TIMED_EVENT_SCHEDULER_LATE_DROP_EN
                    if (is_late_s) begin
                        late_inc_s = 1'b1;
                        if (!fifo_empty_s) begin
                            fifo_pop_s               = 1'b1;
                            {head_ts_d, head_data_d} = fifo_rd_data_s;
                            state_d                  = LOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = WAIT;
                    end
`else
                    state_d = WAIT;
`endif
                end
                WAIT: begin
                    // Late heads satisfy the compare immediately, so they fire on the first run cycle.
                    if (run && (counter >= head_ts_q)) begin
                        evt_valid_d = 1'b1;
                        evt_data_d  = head_data_q;
                        evt_late_d  = late_q;
                        late_inc_s  = late_q;
                        state_d     = FIRE;
                    end else begin
                        state_d = WAIT;
                    end
                end
                FIRE: begin
                    if (evt_ready) begin
                        evt_valid_d = 1'b0;
                        if (!fifo_empty_s) begin
                            fifo_pop_s               = 1'b1;
                            {head_ts_d, head_data_d} = fifo_rd_data_s;
                            state_d                  = LOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = FIRE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        late_count_d = late_inc_s ? sat_inc(late_count_q) : late_count_q;
    end

    // State and output registers.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q      <= IDLE;
            head_ts_q    <= '0;
            head_data_q  <= '0;
            late_q       <= 1'b0;
            evt_valid_q  <= 1'b0;
            evt_data_q   <= '0;
            evt_late_q   <= 1'b0;
            late_count_q <= '0;
            ready_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            head_ts_q    <= head_ts_d;
            head_data_q  <= head_data_d;
            late_q       <= late_d;
            evt_valid_q  <= evt_valid_d;
            evt_data_q   <= evt_data_d;
            evt_late_q   <= evt_late_d;
            late_count_q <= late_count_d;
            ready_en_q   <= 1'b1;
        end
    end

    assign evt_valid  = evt_valid_q;
    assign evt_data   = evt_data_q;
    assign evt_late   = evt_late_q;
    assign late_count = late_count_q;
    assign fill_level = fifo_count_s + (FIFO_ADDR_LEN+1)'(state_q != IDLE);

endmodule

// File: tb/tb_timed_event_scheduler.sv
// Self-checking bench: directed scenarios plus a randomized run against an arithmetic timing model.
module tb_timed_event_scheduler;
    import timed_event_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [63:0] counter = 64'd0;
    logic        run = 1'b0, flush = 1'b0, in_valid = 1'b0, evt_ready = 1'b0;
    logic [63:0] in_timestamp = 64'd0;
    logic [63:0] in_data = 64'd0;
    logic        in_ready, evt_valid, evt_late;
    logic [63:0] evt_data;
    logic [15:0] late_count;
    logic [4:0]  fill_level;

    int n_checks = 0;
    int n_pass   = 0;
    bit cnt_inc  = 1'b0;

`ifdef TIMED_EVENT_SCHEDULER_LATE_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    timed_event_scheduler #(.DATA_WIDTH(64), .FIFO_DEPTH(16), .FIFO_ADDR_LEN(4)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .counter       (counter),
        .run           (run),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_timestamp  (in_timestamp),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_data      (evt_data),
        .evt_late      (evt_late),
        .late_count    (late_count),
        .fill_level    (fill_level)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        if (cnt_inc) counter = counter + 64'd1;
    endtask

    task automatic do_flush;
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic push_one(input logic [63:0] ts, input logic [63:0] data);
        in_valid = 1'b1;
        in_timestamp = ts;
        in_data = data;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (evt_valid === 1'b1) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%0b exp=0", in_ready); else n_pass++;
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL reset_evt_valid got=%0b exp=0", evt_valid); else n_pass++;
        n_checks++; if (evt_data !== 64'd0) $display("FAIL reset_evt_data got=%0h exp=0", evt_data); else n_pass++;
        n_checks++; if (evt_late !== 1'b0) $display("FAIL reset_evt_late got=%0b exp=0", evt_late); else n_pass++;
        n_checks++; if (late_count !== 16'd0) $display("FAIL reset_late_count got=%0d exp=0", late_count); else n_pass++;
        n_checks++; if (fill_level !== 5'd0) $display("FAIL reset_fill got=%0d exp=0", fill_level); else n_pass++;
        rst_n = 1'b1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_release_in_ready got=%0b exp=0", in_ready); else n_pass++;
        tick();
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_first_clk_in_ready got=%0b exp=1", in_ready); else n_pass++;
    endtask

    task automatic test_in_order;
        bit exp_v;
        do_flush();
        counter = 64'd100; cnt_inc = 1'b1; run = 1'b1; evt_ready = 1'b1;
        push_one(64'd120, 64'hA);
        push_one(64'd130, 64'hB);
        while (counter <= 64'd135) begin
            exp_v = (counter == 64'd121) || (counter == 64'd131);
            n_checks++; if (evt_valid !== exp_v) $display("FAIL inorder_valid cnt=%0d got=%0b exp=%0b", counter, evt_valid, exp_v); else n_pass++;
            if (exp_v) begin
                n_checks++; if (evt_data !== ((counter == 64'd121) ? 64'hA : 64'hB)) $display("FAIL inorder_data cnt=%0d got=%0h", counter, evt_data); else n_pass++;
                n_checks++; if (evt_late !== 1'b0) $display("FAIL inorder_late cnt=%0d got=%0b exp=0", counter, evt_late); else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_late;
        logic [15:0] lc0;
        bit ok;
        do_flush();
        lc0 = late_count;
        counter = 64'd500; cnt_inc = 1'b1; run = 1'b1; evt_ready = 1'b1;
        push_one(64'd400, 64'hCAFE);
`ifdef TIMED_EVENT_SCHEDULER_LATE_DROP_EN
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (evt_valid !== 1'b0) $display("FAIL late_drop_valid i=%0d got=%0b exp=0", i, evt_valid); else n_pass++;
            tick();
        end
`else
        wait_valid(10, ok);
        n_checks++; if (!ok) $display("FAIL late_valid_timeout got=0 exp=1"); else n_pass++;
        n_checks++; if (evt_late !== 1'b1) $display("FAIL late_flag got=%0b exp=1", evt_late); else n_pass++;
        n_checks++; if (evt_data !== 64'hCAFE) $display("FAIL late_data got=%0h exp=cafe", evt_data); else n_pass++;
`endif
        n_checks++; if (late_count !== lc0 + 16'd1) $display("FAIL late_count got=%0d exp=%0d", late_count, lc0 + 16'd1); else n_pass++;
    endtask

    task automatic test_backpressure;
        do_flush();
        counter = 64'd0; cnt_inc = 1'b0; run = 1'b0; evt_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_in_ready_before_push i=%0d got=%0b exp=1", i, in_ready); else n_pass++;
            push_one(64'(10 + i), 64'hB000 + 64'(i));
        end
        tick();
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_full_in_ready got=%0b exp=0", in_ready); else n_pass++;
        n_checks++; if (fill_level !== 5'd17) $display("FAIL bp_fill got=%0d exp=17", fill_level); else n_pass++;
        counter = 64'd1000; run = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (evt_valid !== 1'b1) $display("FAIL bp_hold_valid i=%0d got=%0b exp=1", i, evt_valid); else n_pass++;
            n_checks++; if (evt_data !== 64'hB000) $display("FAIL bp_hold_data i=%0d got=%0h exp=b000", i, evt_data); else n_pass++;
            n_checks++; if (evt_late !== 1'b0) $display("FAIL bp_hold_late i=%0d got=%0b exp=0", i, evt_late); else n_pass++;
            tick();
        end
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL bp_after_hs_valid got=%0b exp=0", evt_valid); else n_pass++;
        n_checks++; if (fill_level !== 5'd16) $display("FAIL bp_after_hs_fill got=%0d exp=16", fill_level); else n_pass++;
        tick();
        tick();
`ifndef TIMED_EVENT_SCHEDULER_LATE_DROP_EN
        n_checks++; if (evt_valid !== 1'b1) $display("FAIL bp_second_valid got=%0b exp=1", evt_valid); else n_pass++;
        n_checks++; if (evt_data !== 64'hB001) $display("FAIL bp_second_data got=%0h exp=b001", evt_data); else n_pass++;
        n_checks++; if (evt_late !== 1'b1) $display("FAIL bp_second_late got=%0b exp=1", evt_late); else n_pass++;
`endif
    endtask

    task automatic test_flush;
        logic [15:0] lc0;
        bit ok;
        do_flush();
        counter = 64'd2000; cnt_inc = 1'b0; run = 1'b1; evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_one(64'd2000, 64'hC000 + 64'(i));
        wait_valid(20, ok);
        n_checks++; if (!ok) $display("FAIL flush_setup_timeout got=0 exp=1"); else n_pass++;
        n_checks++; if (evt_data !== 64'hC000) $display("FAIL flush_setup_data got=%0h exp=c000", evt_data); else n_pass++;
        lc0 = late_count;
        flush = 1'b1; in_valid = 1'b1; in_timestamp = 64'd2000; in_data = 64'hDEAD;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL flush_valid got=%0b exp=0", evt_valid); else n_pass++;
        n_checks++; if (fill_level !== 5'd0) $display("FAIL flush_fill got=%0d exp=0", fill_level); else n_pass++;
        n_checks++; if (late_count !== lc0) $display("FAIL flush_late_count got=%0d exp=%0d", late_count, lc0); else n_pass++;
        evt_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++; if (evt_valid !== 1'b0 || fill_level !== 5'd0) $display("FAIL flush_dropped_push i=%0d valid=%0b fill=%0d exp valid=0 fill=0", i, evt_valid, fill_level); else n_pass++;
        end
    endtask

    task automatic test_run_gating;
        do_flush();
        counter = 64'd40; cnt_inc = 1'b1; run = 1'b0; evt_ready = 1'b1;
        push_one(64'd50, 64'h5A5A);
        while (counter < 64'd60) begin
            n_checks++; if (evt_valid !== 1'b0) $display("FAIL gate_no_release cnt=%0d got=%0b exp=0", counter, evt_valid); else n_pass++;
            tick();
        end
        run = 1'b1;
        tick();
        n_checks++; if (evt_valid !== 1'b1) $display("FAIL gate_release_valid got=%0b exp=1", evt_valid); else n_pass++;
        n_checks++; if (evt_late !== 1'b0) $display("FAIL gate_release_late got=%0b exp=0", evt_late); else n_pass++;
        n_checks++; if (evt_data !== 64'h5A5A) $display("FAIL gate_release_data got=%0h exp=5a5a", evt_data); else n_pass++;
    endtask

    // Model: load cycle L = max(prev handshake + 1, push cycle + 2); late = ts < L;
    // release visible at max(ts, L + 1) + 1; a dropped late event "hands off" at L.
    task automatic test_random;
        event_t r_evt[200];
        longint r_p[200], r_l[200], r_v[200], r_h[200];
        bit     r_late[200], r_sched[200];
        int     n, k, exp_fifo, exp_fill, exp_lc;
        longint c, last_ts, prev_h, thr, ts_l;
        bit     exp_valid, exp_ready, rdy;
        logic [15:0] lc0;
        n = 0; k = 0;
        for (int j = 0; j < 200; j++) r_sched[j] = 1'b0;
        do_flush();
        cnt_inc = 1'b0; run = 1'b1; evt_ready = 1'b0;
        lc0 = late_count;
        c = 3000;
        last_ts = c + 8;
        for (int cyc = 0; cyc < 400; cyc++) begin
            counter = 64'(c);
            if (k < n && !r_sched[k]) begin
                prev_h = (k == 0) ? c - 10 : r_h[k-1];
                r_l[k] = (prev_h + 1 > r_p[k] + 2) ? prev_h + 1 : r_p[k] + 2;
                ts_l = longint'(r_evt[k].ts);
                r_late[k] = ts_l < r_l[k];
                r_v[k] = ((ts_l > r_l[k] + 1) ? ts_l : r_l[k] + 1) + 1;
                r_sched[k] = 1'b1;
            end
            exp_valid = (k < n) && r_sched[k] && !(DROP && r_late[k]) && (c >= r_v[k]);
            exp_fill = 0; exp_fifo = 0; exp_lc = int'(lc0);
            for (int j = 0; j < n; j++) begin
                if (r_p[j] < c && (j >= k || c <= r_h[j])) exp_fill++;
                if (r_p[j] < c && !(r_sched[j] && c >= r_l[j])) exp_fifo++;
                thr = DROP ? r_l[j] + 1 : r_v[j];
                if (r_sched[j] && r_late[j] && c >= thr) exp_lc++;
            end
            exp_ready = (exp_fifo < 16);
            n_checks++; if (evt_valid !== exp_valid) $display("FAIL rnd_valid c=%0d got=%0b exp=%0b", c, evt_valid, exp_valid); else n_pass++;
            if (exp_valid) begin
                n_checks++; if (evt_data !== r_evt[k].data) $display("FAIL rnd_data c=%0d got=%0h exp=%0h", c, evt_data, r_evt[k].data); else n_pass++;
                n_checks++; if (evt_late !== r_late[k]) $display("FAIL rnd_late c=%0d got=%0b exp=%0b", c, evt_late, r_late[k]); else n_pass++;
            end
            n_checks++; if (fill_level !== 5'(exp_fill)) $display("FAIL rnd_fill c=%0d got=%0d exp=%0d", c, fill_level, exp_fill); else n_pass++;
            n_checks++; if (in_ready !== exp_ready) $display("FAIL rnd_in_ready c=%0d got=%0b exp=%0b", c, in_ready, exp_ready); else n_pass++;
            n_checks++; if (late_count !== 16'(exp_lc)) $display("FAIL rnd_late_count c=%0d got=%0d exp=%0d", c, late_count, exp_lc); else n_pass++;
            rdy = ($urandom_range(0, 3) != 0);
            evt_ready = rdy;
            if (exp_valid && rdy) begin
                r_h[k] = c;
                k++;
            end else if (k < n && r_sched[k] && DROP && r_late[k] && c == r_l[k]) begin
                r_h[k] = c;
                k++;
            end
            if (exp_ready && n < 200 && $urandom_range(0, 1) == 1) begin
                last_ts = last_ts + longint'($urandom_range(0, 7));
                r_evt[n].ts = 64'(last_ts);
                r_evt[n].data = {$urandom, $urandom};
                r_p[n] = c;
                in_valid = 1'b1;
                in_timestamp = r_evt[n].ts;
                in_data = r_evt[n].data;
                n++;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            c++;
        end
        in_valid = 1'b0;
        evt_ready = 1'b0;
    endtask

    task automatic test_async_reset;
        bit ok;
        do_flush();
        counter = 64'd5000; cnt_inc = 1'b0; run = 1'b1; evt_ready = 1'b0;
        push_one(64'd5000, 64'hE0);
        wait_valid(20, ok);
        n_checks++; if (!ok) $display("FAIL arst_setup_timeout got=0 exp=1"); else n_pass++;
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL arst_evt_valid got=%0b exp=0", evt_valid); else n_pass++;
        n_checks++; if (evt_data !== 64'd0) $display("FAIL arst_evt_data got=%0h exp=0", evt_data); else n_pass++;
        n_checks++; if (evt_late !== 1'b0) $display("FAIL arst_evt_late got=%0b exp=0", evt_late); else n_pass++;
        n_checks++; if (late_count !== 16'd0) $display("FAIL arst_late_count got=%0d exp=0", late_count); else n_pass++;
        n_checks++; if (fill_level !== 5'd0) $display("FAIL arst_fill got=%0d exp=0", fill_level); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL arst_in_ready got=%0b exp=0", in_ready); else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        n_checks++; if (fill_level !== 5'd0) $display("FAIL arst_release_fill got=%0d exp=0", fill_level); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL arst_release_in_ready got=%0b exp=1", in_ready); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_late();
        test_backpressure();
        test_flush();
        test_run_gating();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
